// File: rtl/conv_layer_sequencer.sv
// Descriptor-queue scheduler that replays staged convolution-layer descriptors
// into convController, starts each one, polls it to completion and reports
// progress through a status register and a per-layer irq pulse.
module conv_layer_sequencer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    output logic        slave_waitrequest,
    output logic [2:0]  cc_address,
    output logic        cc_read,
    output logic        cc_write,
    output logic [31:0] cc_writedata,
    input  logic [31:0] cc_readdata,
    input  logic        cc_waitrequest,
    output logic        irq
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned GapW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StPoll, StDone} state_e;

    state_e          state_q;
    logic [2:0]      k_q;
    logic [GapW-1:0] gap_q;
    logic [31:0]     stage_q [6];
    logic [31:0]     fifo_q [DEPTH][6];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;
    logic [15:0]     done_count_q;
    logic            cc_read_q;
    logic            cc_write_q;
    logic [2:0]      cc_address_q;
    logic [31:0]     cc_writedata_q;
    logic            irq_q;

    logic push, push_ok, pop, clr, full, empty, busy;
    logic [7:0] count8;

    assign push    = slave_write && (slave_address == 3'd0);
    assign clr     = slave_write && (slave_address == 3'd7);
    assign pop     = (state_q == StDone);
    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign busy    = (state_q != StIdle);
    // A full queue still accepts a push when the head retires on the same edge.
    assign push_ok = push && (!full || pop);
    assign count8  = 8'(count_q);

    logic unused_inputs;
    assign unused_inputs = ^{slave_read, cc_readdata[31:1]};

    // Descriptor storage: snapshot of the staged words on every accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < 6; i++) begin
                fifo_q[wr_ptr_q][i] <= stage_q[i];
            end
        end
    end

    // CPU-side registers: staging, queue pointers/count, overflow, done count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                stage_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            done_count_q <= '0;
        end else begin
            if (slave_write && (slave_address != 3'd0) && (slave_address != 3'd7)) begin
                stage_q[slave_address - 3'd1] <= slave_writedata;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push_ok && pop) begin
                count_q <= count_q - CntW'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end else if (clr && slave_writedata[0]) begin
                overflow_q <= 1'b0;
            end
            // Clear beats a same-cycle completion.
            if (clr && slave_writedata[1]) begin
                done_count_q <= '0;
            end else if (pop) begin
                done_count_q <= done_count_q + 16'd1;
            end
        end
    end

    // CPU read mux, zero-wait.
    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            3'd0:    slave_readdata = {done_count_q, count8, 4'b0000,
                                       overflow_q, full, empty, busy};
            3'd7:    slave_readdata = {16'b0, done_count_q};
            default: slave_readdata = stage_q[slave_address - 3'd1];
        endcase
    end

    // Master FSM: load six words, start, poll until idle, retire; all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            k_q            <= '0;
            gap_q          <= '0;
            cc_read_q      <= 1'b0;
            cc_write_q     <= 1'b0;
            cc_address_q   <= '0;
            cc_writedata_q <= '0;
            irq_q          <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q        <= StLoad;
                        k_q            <= 3'd1;
                        cc_write_q     <= 1'b1;
                        cc_address_q   <= 3'd1;
                        cc_writedata_q <= fifo_q[rd_ptr_q][0];
                    end
                end
                StLoad: begin
                    if (!cc_waitrequest) begin
                        if (k_q == 3'd6) begin
                            state_q        <= StStart;
                            cc_address_q   <= 3'd0;
                            cc_writedata_q <= '0;
                        end else begin
                            k_q            <= k_q + 3'd1;
                            cc_address_q   <= k_q + 3'd1;
                            cc_writedata_q <= fifo_q[rd_ptr_q][k_q];
                        end
                    end
                end
                StStart: begin
                    if (!cc_waitrequest) begin
                        state_q    <= StWait;
                        cc_write_q <= 1'b0;
                        gap_q      <= GapW'(POLL_GAP);
                    end
                end
                StWait: begin
                    if (gap_q == GapW'(1)) begin
                        state_q      <= StPoll;
                        cc_read_q    <= 1'b1;
                        cc_address_q <= 3'd0;
                    end else begin
                        gap_q <= gap_q - GapW'(1);
                    end
                end
                StPoll: begin
                    if (!cc_waitrequest) begin
                        cc_read_q <= 1'b0;
                        if (cc_readdata[0]) begin
                            state_q <= StWait;
                            gap_q   <= GapW'(POLL_GAP);
                        end else begin
                            state_q <= StDone;
                            irq_q   <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign slave_waitrequest = 1'b0;
    assign cc_read           = cc_read_q;
    assign cc_write          = cc_write_q;
    assign cc_address        = cc_address_q;
    assign cc_writedata      = cc_writedata_q;
    assign irq               = irq_q;

endmodule
